// File: rtl/spi_pkg.sv
// Shared encodings, FSM state type and config clamping helpers for the SPI master slave-select path.
package spi_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_WAIT = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_LAG,
        ST_GAP
    } state_e;

    // Both stop encodings (10, 11) are identified by the upper bit alone.
    function automatic logic mode_stopped(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic int unsigned eff_div(input int unsigned baud);
        int unsigned d;
        d = baud & ~32'd1;
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int unsigned eff_bits(input int unsigned bits, input int unsigned max_bits);
        return (bits == 0 || bits > max_bits) ? max_bits : bits;
    endfunction

endpackage

// File: rtl/spi_phase_counter.sv
// Loadable down-counter with zero flag, reloaded at each sequencer phase entry.
// Load takes effect on the next edge; the count holds at zero until reloaded.
module spi_phase_counter #(
    parameter int W = 18
) (
    input  logic         PCLK,
    input  logic         PRESET_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spi_ss_sequencer.sv
// Slave-select sequencer framing each SPI transfer into LEAD/XFER/LAG/GAP; selects follow state with no added latency.
// Define SS_CONT_EN to add cont_i, which chains a matching request into the next frame with SS held low.
module spi_ss_sequencer
    import spi_pkg::*;
#(
    parameter int  NUM_SS   = 4,
    parameter int  DIV_W    = 12,
    parameter int  MAX_BITS = 32,
    parameter int  DLY_W    = 4,
    localparam int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    localparam int BITS_W   = $clog2(MAX_BITS) + 1,
    localparam int CNT_W    = DIV_W + BITS_W
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic [1:0]        spi_mode_i,
    input  logic              mstr_i,
    input  logic              spiswai_i,
    input  logic              send_data_i,
`ifdef SS_CONT_EN
    input  logic              cont_i,
`endif
    input  logic [SEL_W-1:0]  ss_sel_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [BITS_W-1:0] frame_bits_i,
    input  logic [DLY_W-1:0]  lead_i,
    input  logic [DLY_W-1:0]  lag_i,
    input  logic [DLY_W-1:0]  gap_i,
    output logic [NUM_SS-1:0] ss_o,
    output logic              tip_o,
    output logic              busy_o,
    output logic              receive_data_o,
    output logic              abort_o
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   xfer_len_q;
    logic [DLY_W-1:0]   lag_q, gap_q;
    logic               rx_q, abort_q;

    logic               en, sel_ok, cont_hit, cfg_load;
    logic               cnt_load, cnt_zero, ss_active;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [DIV_W-1:0]   div_eff;
    logic [BITS_W-1:0]  bits_eff;
    logic [CNT_W-1:0]   xfer_len_in;

    assign en = mstr_i && !mode_stopped(spi_mode_i) && (spi_mode_i == MODE_RUN || !spiswai_i);
    assign sel_ok = int'(ss_sel_i) < NUM_SS;

    assign div_eff     = DIV_W'(eff_div(32'(baud_div_i)));
    assign bits_eff    = BITS_W'(eff_bits(32'(frame_bits_i), MAX_BITS));
    assign xfer_len_in = CNT_W'(div_eff) * CNT_W'(bits_eff);

`ifdef SS_CONT_EN
    assign cont_hit = cont_i && send_data_i && en && (ss_sel_i == sel_q);
`else
    assign cont_hit = 1'b0;
`endif

    spi_phase_counter #(.W(CNT_W)) u_phase_cnt (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cfg_load     = 1'b0;
        if (state_q != ST_IDLE && !en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && send_data_i && sel_ok) begin
                        cfg_load = 1'b1;
                        cnt_load = 1'b1;
                        if (lead_i != '0) begin
                            state_d      = ST_LEAD;
                            cnt_load_val = CNT_W'(lead_i) - CNT_W'(1);
                        end else begin
                            state_d      = ST_XFER;
                            cnt_load_val = xfer_len_in - CNT_W'(1);
                        end
                    end
                end
                ST_LEAD: begin
                    if (cnt_zero) begin
                        state_d      = ST_XFER;
                        cnt_load     = 1'b1;
                        cnt_load_val = xfer_len_q - CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        if (cont_hit && lag_q == '0) begin
                            state_d      = ST_XFER;
                            cfg_load     = 1'b1;
                            cnt_load_val = xfer_len_in - CNT_W'(1);
                        end else if (lag_q != '0) begin
                            state_d      = ST_LAG;
                            cnt_load_val = CNT_W'(lag_q) - CNT_W'(1);
                        end else if (gap_q != '0) begin
                            state_d      = ST_GAP;
                            cnt_load_val = CNT_W'(gap_q) - CNT_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_LAG: begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        if (cont_hit) begin
                            state_d      = ST_XFER;
                            cfg_load     = 1'b1;
                            cnt_load_val = xfer_len_in - CNT_W'(1);
                        end else if (gap_q != '0) begin
                            state_d      = ST_GAP;
                            cnt_load_val = CNT_W'(gap_q) - CNT_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Config is captured once per frame so mid-frame register writes cannot disturb timing.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            sel_q      <= '0;
            xfer_len_q <= '0;
            lag_q      <= '0;
            gap_q      <= '0;
        end else if (cfg_load) begin
            sel_q      <= ss_sel_i;
            xfer_len_q <= xfer_len_in;
            lag_q      <= lag_i;
            gap_q      <= gap_i;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            rx_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            rx_q    <= (state_q == ST_XFER) && cnt_zero && en;
            abort_q <= (state_q != ST_IDLE) && !en;
        end
    end

    assign ss_active = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_LAG);

    always_comb begin
        ss_o = '1;
        if (ss_active) begin
            ss_o[sel_q] = 1'b0;
        end
        tip_o          = ss_active;
        busy_o         = (state_q != ST_IDLE);
        receive_data_o = rx_q;
        abort_o        = abort_q;
    end

endmodule

// File: tb/tb_spi_ss_sequencer.sv
// Scoreboard bench: stimulus queues expected frame events, a negedge monitor pops and compares them.
module tb_spi_ss_sequencer;

    typedef enum int {EV_RX, EV_ABORT, EV_SS, EV_BUSY} ev_e;
    typedef struct {
        ev_e        kind;
        int         val;
        logic [3:0] pat;
    } ev_t;

    logic        PCLK = 1'b0;
    logic        PRESET_n = 1'b1;
    logic [1:0]  spi_mode = 2'b00;
    logic        mstr = 1'b1;
    logic        spiswai = 1'b0;
    logic        send = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [2:0]  sel5 = 3'd5;
    logic [11:0] baud = 12'd8;
    logic [5:0]  bits = 6'd8;
    logic [3:0]  lead = 4'd0, lag = 4'd0, gap = 4'd0;
`ifdef SS_CONT_EN
    logic        cont = 1'b0;
`endif

    logic [3:0]  ss_o;
    logic        tip_o, busy_o, receive_data_o, abort_o;
    logic [4:0]  ss5;
    logic        tip5, busy5, rx5, abort5;

    ev_t exp_q[$];
    int  n_chk = 0, n_pass = 0;
    bit  done = 1'b0, final_done = 1'b0;

    always #5 PCLK = ~PCLK;

    spi_ss_sequencer #(.NUM_SS(4), .DIV_W(12), .MAX_BITS(32), .DLY_W(4)) u_dut (
        .PCLK           (PCLK),
        .PRESET_n       (PRESET_n),
        .spi_mode_i     (spi_mode),
        .mstr_i         (mstr),
        .spiswai_i      (spiswai),
        .send_data_i    (send),
`ifdef SS_CONT_EN
        .cont_i         (cont),
`endif
        .ss_sel_i       (sel),
        .baud_div_i     (baud),
        .frame_bits_i   (bits),
        .lead_i         (lead),
        .lag_i          (lag),
        .gap_i          (gap),
        .ss_o           (ss_o),
        .tip_o          (tip_o),
        .busy_o         (busy_o),
        .receive_data_o (receive_data_o),
        .abort_o        (abort_o)
    );

    // Five selects give a 3-bit index, so index 5 is representable but out of range.
    spi_ss_sequencer #(.NUM_SS(5), .DIV_W(12), .MAX_BITS(32), .DLY_W(4)) u_dut5 (
        .PCLK           (PCLK),
        .PRESET_n       (PRESET_n),
        .spi_mode_i     (spi_mode),
        .mstr_i         (mstr),
        .spiswai_i      (spiswai),
        .send_data_i    (send),
`ifdef SS_CONT_EN
        .cont_i         (cont),
`endif
        .ss_sel_i       (sel5),
        .baud_div_i     (baud),
        .frame_bits_i   (bits),
        .lead_i         (lead),
        .lag_i          (lag),
        .gap_i          (gap),
        .ss_o           (ss5),
        .tip_o          (tip5),
        .busy_o         (busy5),
        .receive_data_o (rx5),
        .abort_o        (abort5)
    );

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic mon_check(input ev_e k, input int v, input logic [3:0] p);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event actual=%s/%0d/%b required=none at %0t", k.name(), v, p, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.val == v && e.pat == p) n_pass++;
            else $display("FAIL event actual=%s/%0d/%b required=%s/%0d/%b at %0t",
                          k.name(), v, p, e.kind.name(), e.val, e.pat, $time);
        end
    endtask

    int         age = 0, low_len = 0, busy_len = 0;
    logic [3:0] pat = 4'hF;
    logic       prev_tip = 1'b0, prev_busy = 1'b0;

    always @(negedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            #1;
            chk("reset_outputs", {ss_o, tip_o, busy_o, receive_data_o, abort_o} == 8'hF0,
                int'({ss_o, tip_o, busy_o, receive_data_o, abort_o}), 32'hF0);
            prev_tip  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            chk("ss_tip_onehot", (tip_o == (ss_o != 4'hF)) && ($countones(~ss_o) <= 1),
                int'({tip_o, ss_o}), int'({(ss_o != 4'hF), ss_o}));
            chk("sel_out_of_range_quiet", {ss5, tip5, busy5, rx5, abort5} == 9'h1F0,
                int'({ss5, tip5, busy5, rx5, abort5}), 32'h1F0);
            if (tip_o && !prev_tip) begin
                age     = 0;
                low_len = 0;
                pat     = ss_o;
            end
            if (busy_o && !prev_busy) busy_len = 0;
            if (tip_o)  low_len++;
            if (busy_o) busy_len++;
            if (receive_data_o)      mon_check(EV_RX, age, 4'h0);
            if (abort_o)             mon_check(EV_ABORT, age, 4'h0);
            if (!tip_o && prev_tip)  mon_check(EV_SS, low_len, pat);
            if (!busy_o && prev_busy) mon_check(EV_BUSY, busy_len, 4'h0);
            age++;
            prev_tip  = tip_o;
            prev_busy = busy_o;
            if (done && !final_done) begin
                final_done = 1'b1;
                chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
            end
        end
    end

    task automatic expect_ev(input ev_e k, input int v, input logic [3:0] p);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.pat  = p;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [11:0] b, input logic [5:0] n, input logic [3:0] ld,
                           input logic [3:0] lg, input logic [3:0] gp, input logic [1:0] s);
        baud = b; bits = n; lead = ld; lag = lg; gap = gp; sel = s;
    endtask

    task automatic start_frame();
        @(posedge PCLK);
        #1 send = 1'b1;
        @(posedge PCLK);
        #1 send = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
    endtask

    initial begin
        #1 PRESET_n = 1'b0;
        idle(3);
        #1 PRESET_n = 1'b1;

        // 8x8 frame on select 0, no delays.
        set_cfg(12'd8, 6'd8, 4'd0, 4'd0, 4'd0, 2'd0);
        expect_ev(EV_RX, 64, 4'h0);
        expect_ev(EV_SS, 64, 4'b1110);
        expect_ev(EV_BUSY, 64, 4'h0);
        start_frame();
        idle(80);

        // Odd divisor rounds down, zero bits means the maximum frame.
        set_cfg(12'd5, 6'd0, 4'd0, 4'd0, 4'd0, 2'd1);
        expect_ev(EV_RX, 128, 4'h0);
        expect_ev(EV_SS, 128, 4'b1101);
        expect_ev(EV_BUSY, 128, 4'h0);
        start_frame();
        idle(140);

        set_cfg(12'd1, 6'd3, 4'd0, 4'd0, 4'd0, 2'd3);
        expect_ev(EV_RX, 6, 4'h0);
        expect_ev(EV_SS, 6, 4'b0111);
        expect_ev(EV_BUSY, 6, 4'h0);
        start_frame();
        idle(12);

        // Lead/lag/gap framing; config changes mid-frame and a GAP request must be ignored.
        set_cfg(12'd4, 6'd4, 4'd3, 4'd2, 4'd4, 2'd2);
        expect_ev(EV_RX, 19, 4'h0);
        expect_ev(EV_SS, 21, 4'b1011);
        expect_ev(EV_BUSY, 25, 4'h0);
        start_frame();
        set_cfg(12'd8, 6'd8, 4'd0, 4'd0, 4'd0, 2'd0);
        idle(22);
        #1 send = 1'b1;
        @(posedge PCLK);
        #1 send = 1'b0;
        idle(10);

        // Wait mode with stop-in-wait kills the frame mid-XFER.
        set_cfg(12'd8, 6'd8, 4'd0, 4'd0, 4'd0, 2'd1);
        expect_ev(EV_ABORT, 11, 4'h0);
        expect_ev(EV_SS, 11, 4'b1101);
        expect_ev(EV_BUSY, 11, 4'h0);
        start_frame();
        idle(10);
        #1 spi_mode = 2'b01; spiswai = 1'b1;
        idle(3);
        #1 spi_mode = 2'b00; spiswai = 1'b0;
        set_cfg(12'd2, 6'd2, 4'd0, 4'd0, 4'd0, 2'd0);
        expect_ev(EV_RX, 4, 4'h0);
        expect_ev(EV_SS, 4, 4'b1110);
        expect_ev(EV_BUSY, 4, 4'h0);
        start_frame();
        idle(10);

        // Asynchronous reset in the middle of LAG.
        set_cfg(12'd2, 6'd2, 4'd0, 4'd4, 4'd0, 2'd3);
        expect_ev(EV_RX, 4, 4'h0);
        start_frame();
        idle(5);
        #3 PRESET_n = 1'b0;
        idle(2);
        #1 PRESET_n = 1'b1;
        idle(5);

`ifdef SS_CONT_EN
        // Three chained 16-cycle frames with SS held low throughout.
        set_cfg(12'd2, 6'd8, 4'd0, 4'd0, 4'd0, 2'd0);
        expect_ev(EV_RX, 16, 4'h0);
        expect_ev(EV_RX, 32, 4'h0);
        expect_ev(EV_RX, 48, 4'h0);
        expect_ev(EV_SS, 48, 4'b1110);
        expect_ev(EV_BUSY, 48, 4'h0);
        @(posedge PCLK);
        #1 send = 1'b1; cont = 1'b1;
        @(posedge PCLK);
        idle(33);
        #1 send = 1'b0; cont = 1'b0;
        idle(60);
`endif

        done = 1'b1;
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
